// File: rtl/map_table_pkg.sv
// Shared rename-map definitions: sizes, branch resolution states and the map entry layout.
package map_table_pkg;

  localparam int unsigned MT_NUM     = 32;
  localparam int unsigned MT_IDX_W   = $clog2(MT_NUM);
  localparam int unsigned PRF_IDX_W  = 6;
  localparam int unsigned ENTRY_W    = PRF_IDX_W + 1;
  localparam int unsigned ZERO_REG   = 31;
  localparam int unsigned BR_STATE_W = 2;

  typedef enum logic [BR_STATE_W-1:0] {
    BR_IDLE       = 2'd0,
    BR_PR_CORRECT = 2'd1,
    BR_PR_WRONG   = 2'd2
  } br_state_e;

  typedef struct packed {
    logic                 rdy;
    logic [PRF_IDX_W-1:0] tag;
  } mt_entry_t;

endpackage

// File: rtl/map_table.sv
// R10K rename map table: logical->physical tag map with per-entry ready bits,
// CDB wakeup, branch checkpoint export and mispredict restore.
module map_table
  import map_table_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        disp_en_i,
  input  logic [MT_IDX_W-1:0]         opa_idx_i,
  input  logic [MT_IDX_W-1:0]         opb_idx_i,
  input  logic                        dest_en_i,
  input  logic [MT_IDX_W-1:0]         dest_idx_i,
  input  logic [PRF_IDX_W-1:0]        new_prf_i,
  output logic [PRF_IDX_W-1:0]        opa_prf_o,
  output logic [PRF_IDX_W-1:0]        opb_prf_o,
  output logic                        opa_rdy_o,
  output logic                        opb_rdy_o,
  output logic [PRF_IDX_W-1:0]        old_prf_o,
  input  logic                        cdb_en_i,
  input  logic [PRF_IDX_W-1:0]        cdb_tag_i,
  input  logic [BR_STATE_W-1:0]       br_state_i,
  input  logic [MT_NUM*ENTRY_W-1:0]   rc_mt_all_data_i,
  output logic [MT_NUM*ENTRY_W-1:0]   bak_mp_next_data_o
);

  mt_entry_t map_q [MT_NUM];
  mt_entry_t map_d [MT_NUM];
  logic      recover;
  logic      rename_en;

  assign recover   = (br_state_e'(br_state_i) == BR_PR_WRONG);
  assign rename_en = disp_en_i & dest_en_i & (dest_idx_i != MT_IDX_W'(ZERO_REG)) & ~recover;

  // Source lookups with same-cycle CDB wakeup bypass; reads see the pre-rename map.
  assign opa_prf_o = map_q[opa_idx_i].tag;
  assign opb_prf_o = map_q[opb_idx_i].tag;
  assign opa_rdy_o = map_q[opa_idx_i].rdy | (cdb_en_i & (map_q[opa_idx_i].tag == cdb_tag_i));
  assign opb_rdy_o = map_q[opb_idx_i].rdy | (cdb_en_i & (map_q[opb_idx_i].tag == cdb_tag_i));
  assign old_prf_o = map_q[dest_idx_i].tag;

  // Next map: base (current or recovered), then CDB wakeup, then rename overrides wakeup.
  always_comb begin
    bak_mp_next_data_o = '0;
    for (int i = 0; i < int'(MT_NUM); i++) begin
      if (recover) begin
        map_d[i] = mt_entry_t'(rc_mt_all_data_i[i*ENTRY_W +: ENTRY_W]);
      end else begin
        map_d[i] = map_q[i];
      end
      if (cdb_en_i && (map_d[i].tag == cdb_tag_i)) begin
        map_d[i].rdy = 1'b1;
      end
      if (rename_en && (dest_idx_i == MT_IDX_W'(i))) begin
        map_d[i].rdy = 1'b0;
        map_d[i].tag = new_prf_i;
      end
      if (i == int'(ZERO_REG)) begin
        map_d[i].rdy = 1'b1;
        map_d[i].tag = PRF_IDX_W'(ZERO_REG);
      end
      bak_mp_next_data_o[i*ENTRY_W +: ENTRY_W] = map_d[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(MT_NUM); i++) begin
        map_q[i].rdy <= 1'b1;
        map_q[i].tag <= PRF_IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < int'(MT_NUM); i++) begin
        map_q[i] <= map_d[i];
      end
    end
  end

endmodule
